// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI target endpoint.
//   state_e        FSM states (IDLE, SHIFT)
//   SPI_BITS       frame width in bits
//   UNDERRUN_FILL  byte sent when the TX buffer is empty at a byte boundary
//   SAMPLE_EDGE    which synchronized SCLK edge samples MOSI
// Build option: SPI_TARGET_MODE0_EN selects mode 0 (CPOL=0, CPHA=0);
// without it the target runs in mode 2 (CPOL=1, CPHA=0).
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SPI_BITS = 8;
  localparam logic [SPI_BITS-1:0] UNDERRUN_FILL = 8'hFF;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

`ifdef SPI_TARGET_MODE0_EN
  localparam logic SAMPLE_EDGE = EDGE_RISE;
`else
  localparam logic SAMPLE_EDGE = EDGE_FALL;
`endif

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizer for an asynchronous pin plus registered
// one-cycle rise/fall pulses.
//   clk_i   system clock
//   rst_i   synchronous active-high reset (clears the edge pulses)
//   pin_i   asynchronous pin
//   sync_o  synchronized level (valid 2 clk after the pin changes)
//   rise_o  one-cycle pulse on the 3rd clk after a rising pin edge
//   fall_o  one-cycle pulse on the 3rd clk after a falling pin edge
module spi_pin_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic rise_q, fall_q;

  // The synchronizer chain keeps tracking the pin through reset so that a
  // pin already low/high when reset releases does not produce a false edge.
  always_ff @(posedge clk_i) begin
    meta_q <= pin_i;
    sync_q <= meta_q;
    prev_q <= sync_q;
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI target (slave) endpoint. Deserializes MOSI into bytes and
// serializes bytes from a one-entry TX buffer onto MISO, MSB first, any
// number of bytes per SS-low frame.
//   clk_i           system clock (SCLK phases >= 6 clk each)
//   rst_i           synchronous active-high reset
//   sclk_i, ss_i, mosi_i   asynchronous bus pins (SS active low)
//   miso_o          registered target data
//   miso_oe_o       MISO output enable, high while selected
//   rx_data_o       last complete received byte
//   rx_valid_o      one-cycle pulse, rx_data_o newly updated
//   tx_data_i       next byte to send
//   tx_valid_i      tx_data_i offered
//   tx_ready_o      TX buffer empty; load on tx_valid_i && tx_ready_o
//   tx_underrun_o   one-cycle pulse, UNDERRUN_FILL used for a byte
//   frame_active_o  high in state SHIFT
// Build option: SPI_TARGET_MODE0_EN selects mode 0 (sample on SCLK rise);
// default is mode 2 (sample on SCLK fall).
//
// state | meaning
// IDLE  | not selected, MISO disabled, SCLK edges ignored
// SHIFT | selected, sampling MOSI / shifting MISO
module spi_target
  import spi_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sclk_i,
  input  logic                ss_i,
  input  logic                mosi_i,
  output logic                miso_o,
  output logic                miso_oe_o,
  output logic [SPI_BITS-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic [SPI_BITS-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                tx_underrun_o,
  output logic                frame_active_o
);

  localparam logic [3:0] LAST_CNT = 4'(SPI_BITS);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic ss_rise, ss_fall, ss_sync_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync u_sync_sclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (sclk_i),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_pin_sync u_sync_ss (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (ss_i),
    .sync_o (ss_sync_unused),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_pin_sync u_sync_mosi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (mosi_i),
    .sync_o (mosi_sync),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  logic sample_pulse, shift_pulse;
  assign sample_pulse = (SAMPLE_EDGE == EDGE_RISE) ? sclk_rise : sclk_fall;
  assign shift_pulse  = (SAMPLE_EDGE == EDGE_RISE) ? sclk_fall : sclk_rise;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BITS-1:0] tx_buf_q, tx_buf_d;
  logic                tx_full_q, tx_full_d;
  logic                underrun_q, underrun_d;
  logic                miso_q, miso_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // SS edges take priority over any SCLK edge in the same cycle.
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sample_pulse && (bit_cnt_q < LAST_CNT)) begin
          rx_shift_d = {rx_shift_q[SPI_BITS-2:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          // The TX byte is only consumed once the controller clocks bit 0.
          if (bit_cnt_q == 4'd0) begin
            if (tx_full_q) begin
              tx_shift_d = tx_buf_q;
              tx_full_d  = 1'b0;
            end else begin
              tx_shift_d = UNDERRUN_FILL;
              underrun_d = 1'b1;
            end
          end
          if (bit_cnt_q == LAST_CNT - 4'd1) begin
            rx_data_d  = {rx_shift_q[SPI_BITS-2:0], mosi_sync};
            rx_valid_d = 1'b1;
          end
        end else if (shift_pulse) begin
          if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_d = '0;
          end else if (bit_cnt_q != 4'd0) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a consume refills the buffer.
    if (tx_valid_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  // MISO is registered from next-state values so it moves on the same clk
  // as the counter and shifter rather than one clk later.
  always_comb begin
    miso_d = tx_shift_d[SPI_BITS-1];
    if (bit_cnt_d == 4'd0) begin
      miso_d = tx_full_d ? tx_buf_d[SPI_BITS-1] : UNDERRUN_FILL[SPI_BITS-1];
    end
  end

  assign miso_o         = miso_q;
  assign miso_oe_o      = (state_q == SHIFT);
  assign frame_active_o = (state_q == SHIFT);
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign tx_ready_o     = ~tx_full_q;
  assign tx_underrun_o  = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target acting as the SPI controller.
// Follows SPI_TARGET_MODE0_EN to pick the bus clock polarity.
module tb_spi_target;

`ifdef SPI_TARGET_MODE0_EN
  localparam logic CPOL = 1'b0;
`else
  localparam logic CPOL = 1'b1;
`endif
  localparam int H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = CPOL;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, rx_valid, tx_ready, tx_underrun, frame_active;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int und_cnt = 0;

  always #5 clk = ~clk;

  spi_target dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sclk_i         (sclk),
    .ss_i           (ss),
    .mosi_i         (mosi),
    .miso_o         (miso),
    .miso_oe_o      (miso_oe),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .tx_underrun_o  (tx_underrun),
    .frame_active_o (frame_active)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (tx_underrun === 1'b1) und_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    ss = 1'b0;
    wait_clk(H);
  endtask

  task automatic ss_high();
    wait_clk(H);
    ss = 1'b1;
    wait_clk(H);
  endtask

  // Controller side: MOSI set before the leading edge, MISO captured just
  // before the leading (sample) edge.
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      wait_clk(H);
      mi[i] = miso;
      sclk = ~CPOL;
      wait_clk(H);
      sclk = CPOL;
    end
  endtask

  initial begin
    logic [7:0] mi, mi2, mi3;
    int rx0, und0;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);

    // reset values
    chk("rst_miso", miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_underrun", tx_underrun, 0);
    chk("rst_frame_active", frame_active, 0);

    // single byte: TX A5, RX 3C
    load_tx(8'hA5);
    chk("t1_tx_ready_full", tx_ready, 0);
    rx0 = rx_cnt; und0 = und_cnt;
    ss_low();
    chk("t1_miso_oe", miso_oe, 1);
    chk("t1_frame_active", frame_active, 1);
    chk("t1_peek_msb", miso, 1);
    xfer_bits(8'h3C, 8, mi);
    chk("t1_miso_byte", mi, 8'hA5);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_rx_pulses", rx_cnt - rx0, 1);
    chk("t1_tx_ready_empty", tx_ready, 1);
    chk("t1_underruns", und_cnt - und0, 0);
    ss_high();
    chk("t1_miso_oe_off", miso_oe, 0);
    chk("t1_frame_inactive", frame_active, 0);

    // three-byte frame with underrun on the last byte
    load_tx(8'h11);
    rx0 = rx_cnt; und0 = und_cnt;
    ss_low();
    xfer_bits(8'h01, 8, mi);
    chk("t2_rx0", rx_data, 8'h01);
    load_tx(8'h22);
    xfer_bits(8'h02, 8, mi2);
    chk("t2_rx1", rx_data, 8'h02);
    xfer_bits(8'h03, 8, mi3);
    chk("t2_rx2", rx_data, 8'h03);
    ss_high();
    chk("t2_miso0", mi, 8'h11);
    chk("t2_miso1", mi2, 8'h22);
    chk("t2_miso2", mi3, 8'hFF);
    chk("t2_rx_pulses", rx_cnt - rx0, 3);
    chk("t2_underruns", und_cnt - und0, 1);

    // abort after 4 bits, then full F0 frame
    rx0 = rx_cnt;
    ss_low();
    xfer_bits(8'hAB, 4, mi);
    ss_high();
    chk("t3_abort_no_valid", rx_cnt - rx0, 0);
    chk("t3_abort_rx_kept", rx_data, 8'h03);
    ss_low();
    xfer_bits(8'hF0, 8, mi);
    ss_high();
    chk("t3_rx_f0", rx_data, 8'hF0);
    chk("t3_rx_pulses", rx_cnt - rx0, 1);

    // select without SCLK keeps the buffered byte
    load_tx(8'h5A);
    und0 = und_cnt;
    ss_low();
    ss_high();
    chk("t4_tx_ready_kept", tx_ready, 0);
    ss_low();
    chk("t4_peek_msb", miso, 0);
    xfer_bits(8'h00, 8, mi);
    ss_high();
    chk("t4_miso_byte", mi, 8'h5A);
    chk("t4_tx_ready_empty", tx_ready, 1);
    chk("t4_underruns", und_cnt - und0, 0);

    // reset mid-frame after bit 5
    ss_low();
    xfer_bits(8'h55, 5, mi);
    load_tx(8'h66);
    chk("t5_tx_loaded", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_miso", miso, 1);
    chk("t5_miso_oe", miso_oe, 0);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_rx_valid", rx_valid, 0);
    chk("t5_tx_ready", tx_ready, 1);
    chk("t5_tx_underrun", tx_underrun, 0);
    chk("t5_frame_active", frame_active, 0);
    wait_clk(10);
    chk("t5_stays_idle", frame_active, 0);
    ss = 1'b1;
    wait_clk(H);
    rx0 = rx_cnt; und0 = und_cnt;
    ss_low();
    xfer_bits(8'h99, 8, mi);
    ss_high();
    chk("t5_rx_99", rx_data, 8'h99);
    chk("t5_rx_pulses", rx_cnt - rx0, 1);
    chk("t5_miso_fill", mi, 8'hFF);
    chk("t5_underruns", und_cnt - und0, 1);

    // C3 in, 7E out (mode follows the build option)
    load_tx(8'h7E);
    ss_low();
    xfer_bits(8'hC3, 8, mi);
    ss_high();
    chk("t6_rx_c3", rx_data, 8'hC3);
    chk("t6_miso_7e", mi, 8'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) endpoint, the far end of the SPI master driver: the FPGA answers an external SPI controller on the same four-wire bus. Samples SCLK/SS/MOSI from the pins through 2-flop synchronizers, deserializes MOSI into bytes and serializes bytes from a one-entry transmit buffer onto MISO. Default is SPI mode 2 (CPOL=1, CPHA=0), MSB first, 8-bit frames, any number of bytes per SS-low frame.

## Interface
- `UNDERRUN_FILL`, 8'hFF: byte shifted out when no TX byte is buffered at a byte boundary.
- `clk`  in  1  system clock; SCLK high and low phases each ≥ 6 `clk` periods.
- `rst`  in  1  synchronous, active-high reset.
- `SCLK`  in  1  bus clock from controller (asynchronous).
- `SS`  in  1  active-low select (asynchronous).
- `MOSI`  in  1  controller data (asynchronous).
- `MISO`  out  1  target data.
- `MISO_oe`  out  1  MISO output enable, high only while selected.
- `rx_data`  out  8  last complete received byte.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` newly updated.
- `tx_data`  in  8  next byte to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX buffer empty; load on `tx_valid && tx_ready`.
- `tx_underrun`  out  1  one-cycle pulse, `UNDERRUN_FILL` used for a byte.
- `frame_active`  out  1  high in state SHIFT.

## Operation
- Reset values: `MISO`=1, `MISO_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `frame_active`=0, state IDLE, `bit_cnt`=0, TX buffer empty.
- Edges: sample edge = SCLK falling, shift edge = SCLK rising (mode 2), detected on synchronized SCLK.
- FSM IDLE: `MISO_oe`=0; SS falling edge → SHIFT, `bit_cnt`=0.
- FSM SHIFT: `MISO_oe`=1; SS rising edge → IDLE from any `bit_cnt`.
- `bit_cnt` 4 bits, range 0..8. Sample edge: `rx_shift` ← {`rx_shift`[6:0], MOSI}, `bit_cnt`+1. When `bit_cnt` becomes 8: `rx_data` ← new byte, `rx_valid` pulse.
- Shift edge: `bit_cnt`==8 → `bit_cnt`=0; 1..7 → `tx_shift` ← `tx_shift`<<1; 0 → no action.
- MISO when `bit_cnt`==0: peek, i.e. TX buffer bit 7 if full, else `UNDERRUN_FILL`[7]. Otherwise `tx_shift`[7].
- First sample edge of a byte (`bit_cnt` 0→1): `tx_shift` ← buffer (buffer emptied, `tx_ready`=1 next cycle) or `UNDERRUN_FILL` with `tx_underrun` pulse.
- A TX byte is therefore consumed only if the controller clocks its first bit. The trailing shift edge at frame end consumes nothing.
- Abort (SS rises with `bit_cnt` 1..7): partial RX byte discarded, no `rx_valid`. A consumed TX byte is lost. `bit_cnt` ← 0.
- `tx_valid && tx_ready` in the same cycle as a consume: buffer is refilled, not dropped.
- No RX backpressure. An unread `rx_data` is overwritten.
- SS and SCLK edges in the same cycle: SS edge wins. SCLK edges in IDLE are ignored.

## Timing
- Pin change → synchronized after 2 `clk`, edge pulse on 3rd; registered MISO changes 4 `clk` after the SCLK pin edge.
- First MSB is valid on MISO 4 `clk` after SS falls, before the first sample edge given the SCLK phase rule.
- `rx_valid` asserts 4 `clk` after the 8th sample pin edge.
- `rst` mid-frame: all state to reset values next cycle. The target stays IDLE until the next SS falling edge.

## Configuration
- `SPI_TARGET_MODE0_EN` defined: mode 0 (CPOL=0, CPHA=0). Sample edge = SCLK rising, shift edge = SCLK falling; all other behaviour identical.
- Undefined: mode 2 as above.

## Structure
- Package `spi_pkg`: state enum (IDLE, SHIFT), `SPI_BITS`=8, default `UNDERRUN_FILL`, mode edge-select constants.
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus rise/fall pulse outputs. One instance each for SCLK, SS and MOSI; MOSI edge outputs unused.

## Test plan
- Load 8'hA5, controller sends 8'h3C in mode 2 → `rx_data`=8'h3C, one `rx_valid` pulse, MISO bits 1,0,1,0,0,1,0,1, `tx_ready` back to 1.
- 3-byte frame, MOSI 8'h01,8'h02,8'h03, TX 8'h11,8'h22 loaded on time → three `rx_valid` pulses in order; MISO 8'h11, 8'h22, then 8'hFF with one `tx_underrun` pulse.
- SS rises after 4 bits → no `rx_valid`; next frame with MOSI 8'hF0 → `rx_data`=8'hF0.
- TX 8'h5A loaded, SS low/high with no SCLK → buffer kept, `tx_ready`=0; next frame shifts out 8'h5A.
- `rst` pulse after bit 5 → all outputs at reset values, `MISO_oe`=0; next full frame 8'h99 → `rx_data`=8'h99.
- Build with `SPI_TARGET_MODE0_EN`, CPOL=0 controller sends 8'hC3 with TX 8'h7E → `rx_data`=8'hC3, MISO carries 8'h7E.
